// File: rtl/mascota_pkg.sv
// mascota_pkg: shared encodings and types for the pet food-level and state-machine blocks.
package mascota_pkg;

    typedef logic [1:0] nivel_t;
    typedef logic [1:0] food_state_t;

    localparam food_state_t S_DECAY = 2'b00;
    localparam food_state_t S_FEED  = 2'b01;
    localparam food_state_t S_HOLD  = 2'b10;

    localparam nivel_t LEVEL_FULL  = 2'd3;
    localparam nivel_t LEVEL_EMPTY = 2'd0;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus optional stable-count debouncer for a raw pushbutton.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit FILTER          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic btn
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[0], raw};
    end

    generate
        if (FILTER) begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;
            // any cycle where the input agrees with the output restarts the count
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                    btn <= 1'b0;
                end else if (sync[1] == btn) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    btn <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_raw
            assign btn = sync[1];
        end
    endgenerate

endmodule

// File: rtl/nivel_comida_ctrl.sv
// nivel_comida_ctrl: food level decay/refill generator with conditioned feed button.
// Define DEBOUNCE_EN to filter the button; otherwise it is only synchronized.
module nivel_comida_ctrl
    import mascota_pkg::*;
#(
    parameter int DECAY_TICKS     = 50_000_000,
    parameter int FEED_TICKS      = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   btn_comida_raw,
    input  logic   pause,
    output nivel_t nivel_comida,
    output logic   btn_comida,
    output logic   decay_pulse,
    output logic   level_changed
);

`ifdef DEBOUNCE_EN
    localparam bit DB_FILTER = 1'b1;
`else
    localparam bit DB_FILTER = 1'b0;
`endif

    localparam int DW = $clog2(DECAY_TICKS);
    localparam int FW = $clog2(FEED_TICKS);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);
    localparam logic [FW-1:0] FEED_LAST  = FW'(FEED_TICKS - 1);

    food_state_t   st, nx;
    logic [DW-1:0] decay_cnt;
    logic [FW-1:0] feed_cnt;
    logic          dec, inc;
    nivel_t        nivel_nx;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .FILTER         (DB_FILTER)
    ) u_btn (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_comida_raw),
        .btn  (btn_comida)
    );

    // the state being entered this cycle decides what the counters do
    always_comb begin
        nx       = pause ? S_HOLD : (btn_comida ? S_FEED : S_DECAY);
        dec      = nx == S_DECAY && decay_cnt == DECAY_LAST && nivel_comida != LEVEL_EMPTY;
        inc      = nx == S_FEED && feed_cnt == FEED_LAST && nivel_comida != LEVEL_FULL;
        nivel_nx = dec ? nivel_comida - 1'b1 : (inc ? nivel_comida + 1'b1 : nivel_comida);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= S_DECAY;
            decay_cnt     <= '0;
            feed_cnt      <= '0;
            nivel_comida  <= LEVEL_FULL;
            decay_pulse   <= 1'b0;
            level_changed <= 1'b0;
        end else begin
            st            <= nx;
            decay_cnt     <= nx == S_HOLD ? decay_cnt :
                             (nx == S_FEED || decay_cnt == DECAY_LAST) ? '0 : decay_cnt + 1'b1;
            feed_cnt      <= nx == S_FEED ? (feed_cnt == FEED_LAST ? '0 : feed_cnt + 1'b1) :
                             (nx == S_HOLD && st != S_FEED) ? feed_cnt : '0;
            nivel_comida  <= nivel_nx;
            decay_pulse   <= dec;
            level_changed <= nivel_nx != nivel_comida;
        end
    end

endmodule

// File: tb/tb_nivel_comida_ctrl.sv
// tb_nivel_comida_ctrl: directed checks of food-level decay, feeding, pause, reset and debouncing.
module tb_nivel_comida_ctrl;

`ifdef DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, btn_comida_raw, pause, db_raw;
    logic       btn_comida, decay_pulse, level_changed, db_btn;
    logic [1:0] nivel_comida;
    int         passed = 0, total = 0, n_dec = 0, n_chg = 0, btn_hi = 0, db_hi = 0;

    always #5 clk = ~clk;

    nivel_comida_ctrl #(
        .DECAY_TICKS    (8),
        .FEED_TICKS     (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_comida_raw(btn_comida_raw),
        .pause         (pause),
        .nivel_comida  (nivel_comida),
        .btn_comida    (btn_comida),
        .decay_pulse   (decay_pulse),
        .level_changed (level_changed)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(3),
        .FILTER         (1'b1)
    ) u_db (
        .clk  (clk),
        .reset(reset),
        .raw  (db_raw),
        .btn  (db_btn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else passed++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            n_dec  += int'(decay_pulse);
            n_chg  += int'(level_changed);
            btn_hi += int'(btn_comida);
            db_hi  += int'(db_btn);
        end
    endtask

    initial begin
        reset = 1'b0; btn_comida_raw = 1'b0; pause = 1'b0; db_raw = 1'b0;
        step(2);
        check("rst_lvl", nivel_comida, 3);
        check("rst_btn", btn_comida, 0);
        check("rst_pulse", decay_pulse, 0);
        check("rst_chg", level_changed, 0);
        // idle decay 3 -> 0, no wrap
        reset = 1'b1; n_dec = 0; n_chg = 0;
        step(7); check("idle_e7", nivel_comida, 3);
        step(1); check("idle_e8", nivel_comida, 2);
        check("idle_e8_pulse", decay_pulse, 1);
        check("idle_e8_chg", level_changed, 1);
        step(1); check("idle_e9_pulse", decay_pulse, 0);
        check("idle_e9_chg", level_changed, 0);
        step(7); check("idle_e16", nivel_comida, 1);
        step(8); check("idle_e24", nivel_comida, 0);
        step(8); check("idle_e32", nivel_comida, 0);
        check("idle_e32_pulse", decay_pulse, 0);
        step(8); check("idle_e40", nivel_comida, 0);
        check("idle_ndec", n_dec, 3);
        check("idle_nchg", n_chg, 3);
        // hold feed from empty to full
        btn_comida_raw = 1'b1; n_dec = 0; n_chg = 0;
        step(LAT - 1); check("feed_btn_early", btn_comida, 0);
        step(1); check("feed_btn_rise", btn_comida, 1);
        step(3); check("feed_p3", nivel_comida, 0);
        step(1); check("feed_p4", nivel_comida, 1);
        check("feed_p4_chg", level_changed, 1);
        step(4); check("feed_p8", nivel_comida, 2);
        step(4); check("feed_p12", nivel_comida, 3);
        step(8); check("feed_sat", nivel_comida, 3);
        check("feed_nchg", n_chg, 3);
        check("feed_ndec", n_dec, 0);
        btn_comida_raw = 1'b0;
        step(LAT); check("feed_btn_fall", btn_comida, 0);
        step(7); check("feed_exit_e7", nivel_comida, 3);
        step(1); check("feed_exit_e8", nivel_comida, 2);
        // short press: three feed cycles, no increment, decay restarts
        btn_comida_raw = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            step(1);
            if (i == 3) btn_comida_raw = 1'b0;
            if (i == LAT) check("short_btn_rise", btn_comida, 1);
        end
        check("short_btn_fall", btn_comida, 0);
        check("short_no_inc", nivel_comida, 2);
        step(7); check("short_e7", nivel_comida, 2);
        step(1); check("short_e8", nivel_comida, 1);
        check("short_e8_pulse", decay_pulse, 1);
        // pause at decay_cnt=5 with a button press inside
        step(5);
        pause = 1'b1; btn_comida_raw = 1'b1; n_chg = 0;
        step(LAT); check("pause_btn", btn_comida, 1);
        step(8 - LAT); btn_comida_raw = 1'b0;
        step(12);
        check("pause_btn_low", btn_comida, 0);
        check("pause_lvl", nivel_comida, 1);
        check("pause_nchg", n_chg, 0);
        pause = 1'b0;
        step(2); check("resume_e2", nivel_comida, 1);
        step(1); check("resume_e3", nivel_comida, 0);
        check("resume_pulse", decay_pulse, 1);
        // async reset in the middle of feeding
        btn_comida_raw = 1'b1;
        step(LAT); check("rf_btn", btn_comida, 1);
        step(4); check("rf_lvl1", nivel_comida, 1);
        step(2);
        #1 reset = 1'b0;
        #1;
        check("arst_lvl", nivel_comida, 3);
        check("arst_btn", btn_comida, 0);
        check("arst_pulse", decay_pulse, 0);
        check("arst_chg", level_changed, 0);
        btn_comida_raw = 1'b0;
        step(2); reset = 1'b1;
        step(7); check("rel_e7", nivel_comida, 3);
        step(1); check("rel_e8", nivel_comida, 2);
`ifdef DEBOUNCE_EN
        // bouncing button never passes, decay continues
        btn_hi = 0; n_dec = 0;
        repeat (5) begin
            btn_comida_raw = 1'b1; step(2);
            btn_comida_raw = 1'b0; step(2);
        end
        check("bounce_btn", btn_hi, 0);
        check("bounce_ndec", n_dec, 2);
        check("bounce_lvl", nivel_comida, 0);
`endif
        // stand-alone debouncer
        db_hi = 0;
        repeat (5) begin
            db_raw = 1'b1; step(2);
            db_raw = 1'b0; step(2);
        end
        check("db_bounce", db_hi, 0);
        step(4);
        db_raw = 1'b1;
        step(4); check("db_early", db_btn, 0);
        step(1); check("db_rise", db_btn, 1);
        db_raw = 1'b0;
        step(4); check("db_hold", db_btn, 1);
        step(1); check("db_fall", db_btn, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nivel_comida_ctrl.md
# nivel_comida_ctrl

Food-level generator that sits directly upstream of the pet state machine and produces its 2-bit food level and conditioned feed button. The level decays on a fixed tick while the pet is not being fed and refills while the feed button is held. The raw pushbutton is synchronized and debounced before use.

## Interface

- DECAY_TICKS, 50_000_000: cycles per one-step level decrement (≥2)
- FEED_TICKS, 25_000_000: cycles of continuous feeding per one-step increment (≥2)
- DEBOUNCE_CYCLES, 500_000: stable-input cycles required to accept a button change (≥2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- btn_comida_raw  in  1  raw feed pushbutton, active-high, asynchronous to clk
- pause  in  1  freezes decay and feeding (level held)
- nivel_comida  out  2  food level 0..3, 3 = full; feeds the state machine's Nivel_Comida
- btn_comida  out  1  debounced, synchronized button level; feeds the state machine's Boton_Comida
- decay_pulse  out  1  one-cycle pulse on every decrement that actually lowers the level
- level_changed  out  1  one-cycle pulse whenever nivel_comida changes

## Operation

- Reset values: nivel_comida=3, btn_comida=0, decay_pulse=0, level_changed=0; all counters 0; state S_DECAY.
- Input conditioning: 2-FF synchronizer, then debouncer; btn_comida updates only after the synchronized input differs from btn_comida for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Counters: decay_cnt width $clog2(DECAY_TICKS), feed_cnt width $clog2(FEED_TICKS), unsigned, never exceed terminal value.
- FSM states:
  - S_DECAY: decay_cnt increments each cycle. At decay_cnt==DECAY_TICKS-1: decay_cnt←0. If level>0, level−1 and decay_pulse=1. At level 0, level stays 0 with no pulse (no wrap to 3).
  - S_FEED: decay_cnt held at 0; feed_cnt increments. At feed_cnt==FEED_TICKS-1: feed_cnt←0 and level+1, saturating at 3 (no wrap to 0, no pulse at 3).
  - S_HOLD: both counters keep their values; level frozen.
- Transitions, evaluated in priority order:
  - pause=1 → S_HOLD from any state.
  - Otherwise btn_comida=1 → S_FEED.
  - Otherwise → S_DECAY.
  - Leaving S_FEED clears feed_cnt; partial feeding progress is discarded.
  - Entering S_DECAY from S_FEED starts decay_cnt from 0.
  - Leaving S_HOLD resumes from the held counter values.
- Simultaneous events:
  - pause overrides the button.
  - A button press in the same cycle as decay terminal count: feeding wins and no decrement occurs.
- level_changed asserts in the cycle after any edge where nivel_comida changed value. It is registered alongside nivel_comida, so both change on the same edge.

## Timing

- All outputs are registered; no combinational input-to-output path.
- Button latency (DEBOUNCE_EN defined): btn_comida rises 2+DEBOUNCE_CYCLES edges after a clean btn_comida_raw rise.
- Button latency (DEBOUNCE_EN undefined): 2 edges.
- First decrement after reset release: on the DECAY_TICKS-th rising edge, with no button and no pause.
- Feed increment: FEED_TICKS edges after entry into S_FEED, then every FEED_TICKS edges while the button is held.
- decay_pulse and level_changed are exactly one cycle wide and never overlap a saturated (non-changing) step.
- Reset asserted mid-operation: immediate asynchronous return to reset values. This includes aborting an in-progress debounce.

## Configuration

- DEBOUNCE_EN defined: the debouncer sub-module is instantiated as described.
- DEBOUNCE_EN undefined: btn_comida is the 2-FF synchronized input directly. DEBOUNCE_CYCLES is ignored and no debounce counter is synthesized.

## Structure

- Shared package mascota_pkg holds:
  - food-state encoding: S_DECAY=2'b00, S_FEED=2'b01, S_HOLD=2'b10
  - LEVEL_FULL=2'd3, LEVEL_EMPTY=2'd0
  - the 2-bit level typedef, shared with the state machine
- One sub-module, btn_debounce, contains the synchronizer and debounce counter. It is parameterized by DEBOUNCE_CYCLES and reused for the medicine button later.

## Test plan

Parameters for all scenarios: DECAY_TICKS=8, FEED_TICKS=4, DEBOUNCE_CYCLES=3, DEBOUNCE_EN defined.

- Reset then idle 40 cycles → nivel_comida 3→2→1→0 at edges 8, 16, 24. decay_pulse three times, no pulse at edge 32. Level stays 0, no wrap.
- Level 0, hold btn_comida_raw → btn_comida high after 5 edges. Level 1, 2, 3 at +4, +8, +12 edges. Stays 3 while still held; level_changed pulses exactly 3 times.
- btn_comida_raw toggles every 2 cycles for 20 cycles → btn_comida never rises; decay proceeds normally.
- Level 2, hold button 3 cycles after btn_comida rises, then release → no increment. Next decrement 8 edges after release.
- pause=1 at decay_cnt=5 for 20 cycles, button pressed meanwhile → level unchanged. After pause drops with button released, decrement after exactly 3 more edges.
- Assert reset during S_FEED with feed_cnt=2 and level=1 → asynchronously nivel_comida=3, btn_comida=0, pulses 0. After release, first decrement at edge 8.
